// File: rtl/bus_io_unit.sv
`default_nettype none
// ============================================================================
// Module      : bus_io_unit
// Description : Memory-mapped I/O for a small processor: word RAM, LED
//               register, synchronized switches and an output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_io_unit #(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] DIN,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = PTR_W + 1;
    localparam int RAM_WORDS = 1 << RAM_AW;

    localparam logic [3:0] PAGE_RAM  = 4'h0;
    localparam logic [3:0] PAGE_LED  = 4'h1;
    localparam logic [3:0] PAGE_SW   = 4'h3;
    localparam logic [3:0] PAGE_FIFO = 4'h5;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // Storage
    logic [15:0]       ram_q  [RAM_WORDS];
    logic [15:0]       fifo_q [FIFO_DEPTH];

    // State
    logic [15:0]       din_q,     din_d;
    logic [9:0]        ledr_q,    ledr_d;
    logic [9:0]        sw_meta_q;
    logic [9:0]        sw_sync_q;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              ovf_q,     ovf_d;

    // Decode
    logic [3:0]        page;
    logic [RAM_AW-1:0] ram_idx;
    logic              sel_ram, sel_led, sel_sw, sel_fdata, sel_fstat;
    logic              push_req, pop, full, push_ok;
    logic [15:0]       status;
    logic              unused_addr;

    assign page      = ADDR[15:12];
    assign ram_idx   = ADDR[RAM_AW-1:0];
    assign sel_ram   = (page == PAGE_RAM);
    assign sel_led   = (page == PAGE_LED);
    assign sel_sw    = (page == PAGE_SW);
    assign sel_fdata = (page == PAGE_FIFO) && !ADDR[0];
    assign sel_fstat = (page == PAGE_FIFO) &&  ADDR[0];
    assign unused_addr = ^ADDR[11:1];

    assign out_valid = (count_q != '0);
    assign out_data  = fifo_q[rd_ptr_q];
    assign full      = (count_q == FULL_COUNT);
    assign push_req  = W && sel_fdata;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is kept.
    assign push_ok   = push_req && (!full || pop);
    assign status    = {ovf_q, 15'(count_q)};

    assign DIN  = din_q;
    assign LEDR = ledr_q;

    always_comb begin
        ledr_d   = ledr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        din_d    = 16'h0000;

        if (W && sel_led)
            ledr_d = DOUT[9:0];

        if (push_ok)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push_ok)
            count_d = count_q - CNT_W'(1);

        // Set has priority over a coinciding status-write clear.
        if (W && sel_fstat)
            ovf_d = 1'b0;
        if (push_req && !push_ok)
            ovf_d = 1'b1;

        if (sel_ram)
            din_d = ram_q[ram_idx];
        else if (sel_led)
            din_d = {6'b0, ledr_q};
        else if (sel_sw)
            din_d = {6'b0, sw_sync_q};
        else if (sel_fstat)
            din_d = status;
    end

    // RAM keeps its contents across reset; the read mux sees the old word.
    always_ff @(posedge Clock) begin
        if (W && sel_ram)
            ram_q[ram_idx] <= DOUT;
    end

    always_ff @(posedge Clock) begin
        if (push_ok)
            fifo_q[wr_ptr_q] <= DOUT;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            din_q     <= 16'h0000;
            ledr_q    <= 10'h000;
            sw_meta_q <= 10'h000;
            sw_sync_q <= 10'h000;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            din_q     <= din_d;
            ledr_q    <= ledr_d;
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_io_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_io_unit
// Description : Directed self-checking bench for bus_io_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_io_unit;

    logic        Clock;
    logic        Resetn;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;
    logic [9:0]  SW;
    logic [9:0]  LEDR;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    bus_io_unit #(.RAM_AW(8), .FIFO_DEPTH(4)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .ADDR      (ADDR),
        .DOUT      (DOUT),
        .W         (W),
        .DIN       (DIN),
        .SW        (SW),
        .LEDR      (LEDR),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DOUT = d;
        W    = 1'b1;
        tick();
        W    = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        ADDR = a;
        W    = 1'b0;
        tick();
        check_eq(tag, DIN, exp);
    endtask

    task automatic drain(input string tag, input logic [15:0] first, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_valid"}, {15'b0, out_valid}, 16'h0001);
            check_eq({tag, "_data"}, out_data, first + 16'(i));
            tick();
        end
        check_eq({tag, "_empty"}, {15'b0, out_valid}, 16'h0000);
        out_ready = 1'b0;
    endtask

    initial begin
        Resetn    = 1'b0;
        ADDR      = 16'h0000;
        DOUT      = 16'h0000;
        W         = 1'b0;
        SW        = 10'h000;
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_din",   DIN,               16'h0000);
        check_eq("rst_ledr",  {6'b0, LEDR},      16'h0000);
        check_eq("rst_valid", {15'b0, out_valid}, 16'h0000);
        Resetn = 1'b1;
        tick();

        // RAM path, aliasing and read-before-write
        bus_write(16'h0012, 16'hBEEF);
        bus_read("ram_rd",    16'h0012, 16'hBEEF);
        bus_read("ram_alias", 16'h0F12, 16'hBEEF);
        ADDR = 16'h0012; DOUT = 16'h1234; W = 1'b1;
        tick();
        check_eq("ram_rbw_old", DIN, 16'hBEEF);
        W = 1'b0;
        tick();
        check_eq("ram_rbw_new", DIN, 16'h1234);

        // LEDs and switches
        bus_write(16'h1000, 16'hFFFF);
        check_eq("ledr_wr", {6'b0, LEDR}, 16'h03FF);
        bus_read("ledr_rd", 16'h1000, 16'h03FF);
        SW   = 10'h155;
        ADDR = 16'h3000;
        tick();
        tick();
        tick();
        check_eq("sw_sync", DIN, 16'h0155);
        bus_write(16'h3000, 16'h0000);
        bus_read("sw_wr_ignored", 16'h3000, 16'h0155);

        // Unmapped page
        bus_write(16'h7000, 16'h00AA);
        bus_read("unmapped_rd", 16'h7000, 16'h0000);
        check_eq("unmapped_ledr", {6'b0, LEDR}, 16'h03FF);
        bus_read("unmapped_ram", 16'h0012, 16'h1234);

        // FIFO fill, overflow, ordered drain
        for (int i = 1; i <= 4; i++) bus_write(16'h5000, 16'(i));
        bus_read("fifo_stat4", 16'h5001, 16'h0004);
        bus_write(16'h5000, 16'h0005);
        bus_read("fifo_ovf",   16'h5001, 16'h8004);
        bus_read("fifo_data0", 16'h5000, 16'h0000);
        drain("drain1", 16'h0001, 4);
        bus_read("stat_after_drain", 16'h5001, 16'h8000);
        bus_write(16'h5001, 16'h1234);
        bus_read("ovf_clear", 16'h5001, 16'h0000);

        // Full FIFO with simultaneous push and pop, across pointer wrap
        for (int i = 5; i <= 8; i++) bus_write(16'h5000, 16'(i));
        ADDR = 16'h5000; DOUT = 16'h0009; W = 1'b1; out_ready = 1'b1;
        tick();
        W = 1'b0; out_ready = 1'b0;
        bus_read("full_pushpop", 16'h5001, 16'h0004);
        drain("drain2", 16'h0006, 4);

        // Reset mid-stream, with a push attempted during reset
        bus_write(16'h5000, 16'h000A);
        bus_write(16'h5000, 16'h000B);
        bus_write(16'h5000, 16'h000C);
        bus_write(16'h1000, 16'h02A5);
        check_eq("ledr_2a5", {6'b0, LEDR}, 16'h02A5);
        bus_read("stat3", 16'h5001, 16'h0003);
        Resetn = 1'b0; ADDR = 16'h5000; DOUT = 16'h00DD; W = 1'b1;
        tick();
        Resetn = 1'b1; W = 1'b0;
        check_eq("mid_rst_din",   DIN,               16'h0000);
        check_eq("mid_rst_valid", {15'b0, out_valid}, 16'h0000);
        check_eq("mid_rst_ledr",  {6'b0, LEDR},      16'h0000);
        bus_read("mid_rst_stat", 16'h5001, 16'h0000);
        bus_read("mid_rst_ram",  16'h0012, 16'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
